// File: rtl/lisa_pkg.sv
// Shared types and constants for the LISA fetch path.
package lisa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [7:0] OPC_HALT       = 8'h00;
  localparam int         MAX_INSN_BYTES = 5;

  // Length field lives in opcode[7:6]
  localparam logic [1:0] LENF_1 = 2'b00;
  localparam logic [1:0] LENF_2 = 2'b01;
  localparam logic [1:0] LENF_3 = 2'b10;
  localparam logic [1:0] LENF_5 = 2'b11;

  localparam logic [2:0] LEN_1 = 3'd1;
  localparam logic [2:0] LEN_2 = 3'd2;
  localparam logic [2:0] LEN_3 = 3'd3;
  localparam logic [2:0] LEN_5 = 3'd5;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  opcode;
    logic [31:0] operand;
    logic [2:0]  len;
  } insn_t;

  function automatic logic [2:0] decode_len(input logic [7:0] opcode);
    logic [2:0] len;
    case (opcode[7:6])
      LENF_1:  len = LEN_1;
      LENF_2:  len = LEN_2;
      LENF_3:  len = LEN_3;
      LENF_5:  len = LEN_5;
      default: len = LEN_1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/lisa_ilen.sv
// Combinational length decoder: splits the first bytes of a fetch window
// into opcode, zero-extended little-endian operand and instruction length.
module lisa_ilen
  import lisa_pkg::*;
(
  input  logic [MAX_INSN_BYTES*8-1:0] window,
  output logic [2:0]                  len,
  output logic [7:0]                  opcode,
  output logic [31:0]                 operand
);

  // Operand bytes past the decoded length are forced to zero
  always_comb begin
    opcode  = window[7:0];
    len     = decode_len(window[7:0]);
    operand = '0;
    case (len)
      LEN_2:   operand = {24'h0, window[15:8]};
      LEN_3:   operand = {16'h0, window[23:8]};
      LEN_5:   operand = window[39:8];
      default: operand = '0;
    endcase
  end

endmodule

// File: rtl/lisa_fetch.sv
// Instruction fetch unit: owns the PC, decodes one variable-length
// instruction per cycle from the imem window and registers it for decode.
module lisa_fetch
  import lisa_pkg::*;
#(
  parameter int MEM_BYTES   = 512,
  parameter int FETCH_BYTES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [15:0]              start_pc,
  output logic [15:0]              fetch_addr,
  input  logic [FETCH_BYTES*8-1:0] fetch_window,
  input  logic                     redirect_valid,
  input  logic [15:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_pc,
  output logic [7:0]               out_opcode,
  output logic [31:0]              out_operand,
  output logic [2:0]               out_len,
  output logic                     halted,
  output logic                     fault
);

  localparam logic [16:0] MEM_LIMIT = 17'(MEM_BYTES);

  state_t      state_q, state_d;
  logic [15:0] pc_p0, pc_d;
  insn_t       insn_p1, insn_d;
  logic        vld_p1, vld_d;

  logic [2:0]  dec_len;
  logic [7:0]  dec_opcode;
  logic [31:0] dec_operand;
  logic [16:0] next_pc_ext;
  logic        can_capture;

  lisa_ilen u_ilen (
    .window  (fetch_window[MAX_INSN_BYTES*8-1:0]),
    .len     (dec_len),
    .opcode  (dec_opcode),
    .operand (dec_operand)
  );

  // Bytes beyond the longest instruction are never looked at
  if (FETCH_BYTES > MAX_INSN_BYTES) begin : g_spare
    logic unused_window;
    assign unused_window = ^fetch_window[FETCH_BYTES*8-1:MAX_INSN_BYTES*8];
  end

  // 17-bit sum so an instruction straddling the top of memory is caught
  assign next_pc_ext = {1'b0, pc_p0} + {14'b0, dec_len};
  assign can_capture = !vld_p1 || out_ready;

  // Next-state, PC and output-register update; priority start > redirect > capture
  always_comb begin
    state_d = state_q;
    pc_d    = pc_p0;
    vld_d   = vld_p1;
    insn_d  = insn_p1;
    if (start) begin
      state_d = ST_RUN;
      pc_d    = start_pc;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (redirect_valid) begin
            pc_d  = redirect_pc;
            vld_d = 1'b0;
          end else if (can_capture) begin
            if (next_pc_ext > MEM_LIMIT) begin
              state_d = ST_FAULT;
              vld_d   = 1'b0;
            end else begin
              insn_d = '{pc: pc_p0, opcode: dec_opcode,
                         operand: dec_operand, len: dec_len};
              vld_d  = 1'b1;
              if (dec_opcode == OPC_HALT) state_d = ST_HALT;
              else                        pc_d    = next_pc_ext[15:0];
            end
          end
        end
        ST_HALT, ST_FAULT: begin
          if (out_ready) vld_d = 1'b0;
        end
        default: begin
          vld_d = 1'b0;
        end
      endcase
    end
  end

  // ---- stage p0 -> p1: PC/state and registered instruction ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_p0   <= '0;
      vld_p1  <= 1'b0;
      insn_p1 <= '0;
    end else begin
      state_q <= state_d;
      pc_p0   <= pc_d;
      vld_p1  <= vld_d;
      insn_p1 <= insn_d;
    end
  end

  assign fetch_addr  = pc_p0;
  assign out_valid   = vld_p1;
  assign out_pc      = insn_p1.pc;
  assign out_opcode  = insn_p1.opcode;
  assign out_operand = insn_p1.operand;
  assign out_len     = insn_p1.len;
  assign halted      = (state_q == ST_HALT);
  assign fault       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_lisa_fetch.sv
// Bench for lisa_fetch: directed scenarios plus randomized programs checked
// against an architectural walk of memory kept in a queue.
module tb_lisa_fetch;

  localparam int MEM_BYTES   = 512;
  localparam int FETCH_BYTES = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, start, redirect_valid, out_ready;
  logic [15:0]              start_pc, redirect_pc, fetch_addr, out_pc;
  logic [FETCH_BYTES*8-1:0] fetch_window;
  logic                     out_valid, halted, fault;
  logic [7:0]               out_opcode;
  logic [31:0]              out_operand;
  logic [2:0]               out_len;

  logic [7:0] mem [MEM_BYTES];

  typedef struct {
    int          pc;
    int          op;
    logic [31:0] operand;
    int          len;
  } exp_t;

  exp_t exp_q[$];
  int   exp_end;      // 1 = ends in HALT, 2 = ends in FAULT
  int   vectors     = 0;
  int   miscompares = 0;

  lisa_fetch #(.MEM_BYTES(MEM_BYTES), .FETCH_BYTES(FETCH_BYTES)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_pc       (start_pc),
    .fetch_addr     (fetch_addr),
    .fetch_window   (fetch_window),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_opcode     (out_opcode),
    .out_operand    (out_operand),
    .out_len        (out_len),
    .halted         (halted),
    .fault          (fault)
  );

  // Behavioural imem: bytes past the end of memory read as zero
  always_comb begin
    fetch_window = '0;
    for (int i = 0; i < FETCH_BYTES; i++) begin
      int a;
      logic [8:0] ix;
      a  = int'(fetch_addr) + i;
      ix = a[8:0];
      if (a < MEM_BYTES) fetch_window[8*i +: 8] = mem[ix];
    end
  end

  function automatic logic [7:0] rd(input int a);
    logic [8:0] ix;
    ix = a[8:0];
    return (a < MEM_BYTES) ? mem[ix] : 8'h00;
  endfunction

  task automatic wr(input int a, input logic [7:0] b);
    logic [8:0] ix;
    ix = a[8:0];
    mem[ix] = b;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < MEM_BYTES; a++) wr(a, 8'h00);
  endtask

  // Architectural walk: list every instruction executed from start_at
  function automatic void walk(input int start_at);
    int pc, op, len;
    logic [31:0] opnd;
    exp_q.delete();
    pc = start_at;
    for (int n = 0; n < 1024; n++) begin
      op  = int'(rd(pc));
      len = (op < 64) ? 1 : (op < 128) ? 2 : (op < 192) ? 3 : 5;
      if (pc + len > MEM_BYTES) begin
        exp_end = 2;
        return;
      end
      opnd = '0;
      for (int k = len - 1; k >= 1; k--) opnd = (opnd << 8) | 32'(rd(pc + k));
      exp_q.push_back('{pc, op, opnd, len});
      if (op == 0) begin
        exp_end = 1;
        return;
      end
      pc += len;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score any transfer at the coming edge, then check hold-stability
  task automatic tick();
    logic        hold;
    logic [58:0] held;
    logic [15:0] held_addr;
    exp_t        e;
    hold      = out_valid && !out_ready && !start && !redirect_valid && !rst;
    held      = {out_pc, out_opcode, out_operand, out_len};
    held_addr = fetch_addr;
    if (out_valid && out_ready && !rst) begin
      chk("xfer_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("xfer_fields", 64'({out_pc, out_opcode, out_operand, out_len}),
            64'({16'(e.pc), 8'(e.op), e.operand, 3'(e.len)}));
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_fields", 64'({out_pc, out_opcode, out_operand, out_len}), 64'(held));
      chk("hold_pc", 64'(fetch_addr), 64'(held_addr));
    end
  endtask

  task automatic check_reset_values();
    chk("rst_fetch_addr", 64'(fetch_addr), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_opcode", 64'(out_opcode), 64'd0);
    chk("rst_out_operand", 64'(out_operand), 64'd0);
    chk("rst_out_len", 64'(out_len), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
  endtask

  // Run until the expected stream is consumed and the unit has stopped
  task automatic drain(input int bound, input bit rnd_ready, input bit rnd_redirect);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !out_valid && (halted || fault)) && n < bound) begin
      if (rnd_ready) out_ready = ($urandom % 4) != 0;
      if (rnd_redirect && exp_q.size() >= 2 && ($urandom % 40) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 16'($urandom_range(0, MEM_BYTES - 1));
      end
      tick();
      if (redirect_valid) begin
        walk(int'(redirect_pc));
        redirect_valid = 1'b0;
      end
      n++;
    end
    out_ready = 1'b1;
    chk("drain_in_budget", 64'(n < bound), 64'd1);
    chk("end_halted", 64'(halted), 64'(exp_end == 1));
    chk("end_fault", 64'(fault), 64'(exp_end == 2));
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_start(input int pc);
    start    = 1'b1;
    start_pc = 16'(pc);
    walk(pc);
    tick();
    start    = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start_pc = '0; redirect_valid = 1'b0;
    redirect_pc = '0; out_ready = 1'b0; exp_end = 0;
    clear_mem();
    tick();
    tick();
    check_reset_values();
    rst = 1'b0;
    tick();
    chk("idle_no_valid", 64'(out_valid), 64'd0);

    // Straight-line program with out_ready held high
    wr(16'h10, 8'h41); wr(16'h11, 8'hAA);
    wr(16'h12, 8'hC2); wr(16'h13, 8'h78); wr(16'h14, 8'h56);
    wr(16'h15, 8'h34); wr(16'h16, 8'h12); wr(16'h17, 8'h00);
    out_ready = 1'b1;
    do_start(16'h10);
    chk("start_fetch_addr", 64'(fetch_addr), 64'h10);
    chk("start_no_valid", 64'(out_valid), 64'd0);
    tick();
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("i0_pc", 64'(out_pc), 64'h10);
    chk("i0_len", 64'(out_len), 64'd2);
    chk("i0_operand", 64'(out_operand), 64'hAA);
    tick();
    chk("i1_pc", 64'(out_pc), 64'h12);
    chk("i1_len", 64'(out_len), 64'd5);
    chk("i1_operand", 64'(out_operand), 64'h12345678);
    tick();
    chk("i2_pc", 64'(out_pc), 64'h17);
    chk("i2_opcode", 64'(out_opcode), 64'h00);
    chk("halted_rise", 64'(halted), 64'd1);
    tick();
    chk("halt_drained", 64'(out_valid), 64'd0);
    chk("halt_pc_held", 64'(fetch_addr), 64'h17);
    chk("halt_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("halt_stays", 64'(halted), 64'd1);

    // Backpressure on the second instruction (also restarts from HALT)
    do_start(16'h10);
    chk("restart_clears_halted", 64'(halted), 64'd0);
    tick();
    tick();
    chk("bp_second_pc", 64'(out_pc), 64'h12);
    out_ready = 1'b0;
    repeat (3) tick();
    chk("bp_pc_not_advanced", 64'(fetch_addr), 64'h17);
    out_ready = 1'b1;
    drain(50, 1'b0, 1'b0);

    // Redirect while the instruction at 0x12 is valid
    wr(16'h40, 8'h81); wr(16'h41, 8'h34); wr(16'h42, 8'h12);
    wr(16'h43, 8'h05); wr(16'h44, 8'h00);
    do_start(16'h10);
    tick();
    tick();
    chk("pre_redirect_pc", 64'(out_pc), 64'h12);
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h40;
    tick();
    walk(16'h40);
    redirect_valid = 1'b0;
    chk("redirect_flush", 64'(out_valid), 64'd0);
    chk("redirect_fetch_addr", 64'(fetch_addr), 64'h40);
    out_ready = 1'b1;
    tick();
    chk("redirect_target_valid", 64'(out_valid), 64'd1);
    chk("redirect_target_pc", 64'(out_pc), 64'h40);
    chk("redirect_target_operand", 64'(out_operand), 64'h1234);
    drain(50, 1'b0, 1'b0);

    // Restart from HALT at address 0
    wr(0, 8'h3F); wr(1, 8'h7E); wr(2, 8'h11); wr(3, 8'h00);
    do_start(0);
    chk("restart0_halted_low", 64'(halted), 64'd0);
    chk("restart0_fetch_addr", 64'(fetch_addr), 64'd0);
    drain(50, 1'b0, 1'b0);

    // End of memory: 5-byte opcode at 0x1FE cannot fit
    wr(16'h1FB, 8'h41); wr(16'h1FC, 8'h99); wr(16'h1FD, 8'h01);
    wr(16'h1FE, 8'hC0); wr(16'h1FF, 8'h00);
    do_start(16'h1FB);
    tick();
    tick();
    chk("eom_last_good_pc", 64'(out_pc), 64'h1FD);
    out_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    chk("fault_rise", 64'(fault), 64'd1);
    chk("fault_no_valid", 64'(out_valid), 64'd0);
    chk("fault_fetch_addr", 64'(fetch_addr), 64'h1FE);
    chk("fault_queue_empty", 64'(exp_q.size()), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h40;
    tick();
    redirect_valid = 1'b0;
    chk("fault_ignores_redirect", 64'(fetch_addr), 64'h1FE);
    chk("fault_stays", 64'(fault), 64'd1);
    chk("fault_still_no_valid", 64'(out_valid), 64'd0);

    // Reset mid-stream with an instruction pending
    out_ready = 1'b0;
    do_start(16'h10);
    tick();
    chk("pending_before_rst", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check_reset_values();
    tick();
    chk("post_rst_idle_valid", 64'(out_valid), 64'd0);
    chk("post_rst_idle_addr", 64'(fetch_addr), 64'd0);

    // Randomized programs, random backpressure and occasional redirects
    for (int run = 0; run < 25; run++) begin
      for (int a = 0; a < MEM_BYTES; a++)
        wr(a, (($urandom % 48) == 0) ? 8'h00 : 8'($urandom));
      out_ready = ($urandom % 2) != 0;
      do_start($urandom_range(0, MEM_BYTES - 1));
      drain(3000, 1'b1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
